// File: rtl/round_key_mux11.sv
// -----------------------------------------------------------------------------
// round_key_mux11
//
// Collects up to NK round keys written by slot index into a local key store.
// On start it replays them in order 0..NK-1 to the cipher datapath over a
// valid/ready stream, one key per accepted handshake.
//
// Ports:
//   clk_i        single clock, all state on the rising edge
//   rst_i        asynchronous, active-high reset
//   wr_en_i      key store write strobe
//   wr_idx_i     slot index for the write
//   wr_key_i     key data for the write
//   clear_i      clears loaded flags and err (IDLE only)
//   start_i      single-cycle replay request
//   key_out_o    current round key (registered)
//   key_idx_o    slot index of key_out_o (registered)
//   key_valid_o  key_out_o / key_idx_o valid
//   key_ready_i  consumer accepts the current key
//   key_last_o   high with key_valid_o on the final slot
//   busy_o       high while replaying
//   done_o       one-cycle pulse after the final handshake
//   loaded_o     per-slot loaded flags
//   err_o        sticky error flag, cleared by rst_i or clear_i
//   dbg_state_o  FSM state (0 = IDLE, 1 = RUN)
//
// Stream handshake: a key transfers on every rising edge where
// key_valid_o && key_ready_i. While key_valid_o is high and key_ready_i is
// low, key_out_o, key_idx_o and key_valid_o hold their values. key_valid_o
// never depends combinationally on key_ready_i.
// -----------------------------------------------------------------------------
module round_key_mux11 #(
    parameter int W  = 128,
    parameter int NK = 11
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          wr_en_i,
    input  logic [3:0]    wr_idx_i,
    input  logic [W-1:0]  wr_key_i,
    input  logic          clear_i,
    input  logic          start_i,
    output logic [W-1:0]  key_out_o,
    output logic [3:0]    key_idx_o,
    output logic          key_valid_o,
    input  logic          key_ready_i,
    output logic          key_last_o,
    output logic          busy_o,
    output logic          done_o,
    output logic [NK-1:0] loaded_o,
    output logic          err_o,
    output logic          dbg_state_o
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [3:0] LAST_IDX = 4'(NK - 1);

    state_t         state_q;
    logic [3:0]     ptr_q;
    logic [3:0]     ptr_d;
    logic [W-1:0]   key_out_q;
    logic [3:0]     key_idx_q;
    logic           key_valid_q;
    logic           done_q;
    logic [NK-1:0]  loaded_q;
    logic           err_q;

    // Key data is deliberately not reset: slots are only replayed once their
    // loaded flag is set, and the flags are reset.
    logic [W-1:0]   key_mem [NK];

    logic idx_ok;
    logic full;
    logic hs;
    logic store_we;

    assign idx_ok   = (wr_idx_i <= LAST_IDX);
    assign full     = &loaded_q;
    assign hs       = key_valid_q & key_ready_i;
    assign ptr_d    = ptr_q + 4'd1;
    // The store is locked during replay; clear in the same cycle discards the
    // write because the slot would be marked unloaded anyway.
    assign store_we = (state_q == S_IDLE) & wr_en_i & idx_ok & ~clear_i;

    always_ff @(posedge clk_i) begin
        if (store_we) begin
            key_mem[wr_idx_i] <= wr_key_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            ptr_q       <= 4'd0;
            key_out_q   <= '0;
            key_idx_q   <= 4'd0;
            key_valid_q <= 1'b0;
            done_q      <= 1'b0;
            loaded_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (clear_i) begin
                        loaded_q <= '0;
                        // Only an out-of-range write survives a same-cycle clear.
                        err_q    <= wr_en_i & ~idx_ok;
                    end else begin
                        if (store_we) begin
                            loaded_q[wr_idx_i] <= 1'b1;
                        end
                        if ((wr_en_i & ~idx_ok) | (start_i & ~full)) begin
                            err_q <= 1'b1;
                        end
                    end
                    // full is the pre-cycle bitmap, so a same-cycle write
                    // cannot complete the set in time for this start.
                    if (start_i & full) begin
                        state_q     <= S_RUN;
                        ptr_q       <= 4'd0;
                        key_out_q   <= key_mem[0];
                        key_idx_q   <= 4'd0;
                        key_valid_q <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (wr_en_i) begin
                        err_q <= 1'b1;
                    end
                    if (hs) begin
                        if (ptr_q == LAST_IDX) begin
                            state_q     <= S_IDLE;
                            ptr_q       <= 4'd0;
                            key_valid_q <= 1'b0;
                            done_q      <= 1'b1;
                        end else begin
                            ptr_q     <= ptr_d;
                            key_out_q <= key_mem[ptr_d];
                            key_idx_q <= ptr_d;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign key_out_o   = key_out_q;
    assign key_idx_o   = key_idx_q;
    assign key_valid_o = key_valid_q;
    assign key_last_o  = key_valid_q & (key_idx_q == LAST_IDX);
    assign busy_o      = (state_q == S_RUN);
    assign done_o      = done_q;
    assign loaded_o    = loaded_q;
    assign err_o       = err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_round_key_mux11.sv
// -----------------------------------------------------------------------------
// tb_round_key_mux11
//
// Directed bench for round_key_mux11: key loading, full replay, incomplete
// start, backpressure, store locking, reset mid-replay and back-to-back replay.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_round_key_mux11;

    localparam int W  = 128;
    localparam int NK = 11;

    logic          clk;
    logic          rst;
    logic          wr_en;
    logic [3:0]    wr_idx;
    logic [W-1:0]  wr_key;
    logic          clear;
    logic          start;
    logic [W-1:0]  key_out;
    logic [3:0]    key_idx;
    logic          key_valid;
    logic          key_ready;
    logic          key_last;
    logic          busy;
    logic          done;
    logic [NK-1:0] loaded;
    logic          err;
    logic          dbg_state;

    int n_vec  = 0;
    int n_fail = 0;

    localparam logic [W-1:0] K3_ALT  = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
    localparam logic [W-1:0] K3_RUN  = 128'hdead_beef_dead_beef_dead_beef_dead_beef;

    logic [W-1:0] rec_q[$];

    round_key_mux11 #(.W(W), .NK(NK)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .wr_en_i     (wr_en),
        .wr_idx_i    (wr_idx),
        .wr_key_i    (wr_key),
        .clear_i     (clear),
        .start_i     (start),
        .key_out_o   (key_out),
        .key_idx_o   (key_idx),
        .key_valid_o (key_valid),
        .key_ready_i (key_ready),
        .key_last_o  (key_last),
        .busy_o      (busy),
        .done_o      (done),
        .loaded_o    (loaded),
        .err_o       (err),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic write_key(input logic [3:0] idx, input logic [W-1:0] data);
        wr_en  = 1'b1;
        wr_idx = idx;
        wr_key = data;
        step();
        wr_en  = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic load_all();
        for (int i = 0; i < NK; i++) begin
            write_key(4'(i), {120'h0, 8'(i)});
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst       = 1'b1;
        wr_en     = 1'b0;
        wr_idx    = 4'd0;
        wr_key    = '0;
        clear     = 1'b0;
        start     = 1'b0;
        key_ready = 1'b0;
        #3;
        check("rst_key_out",   key_out,   '0);
        check("rst_key_idx",   W'(key_idx), '0);
        check("rst_key_valid", W'(key_valid), '0);
        check("rst_key_last",  W'(key_last), '0);
        check("rst_busy",      W'(busy),  '0);
        check("rst_done",      W'(done),  '0);
        check("rst_loaded",    W'(loaded), '0);
        check("rst_err",       W'(err),   '0);
        step();
        rst = 1'b0;
        step();

        // ---- full load, streaming replay with ready held high ----
        load_all();
        check("t1_loaded", W'(loaded), W'(11'h7ff));
        key_ready = 1'b1;
        pulse_start();
        check("t1_busy_start", W'(busy), W'(1'b1));
        for (int i = 0; i < NK; i++) begin
            check($sformatf("t1_idx%0d", i),   W'(key_idx), W'(i));
            check($sformatf("t1_key%0d", i),   key_out, {120'h0, 8'(i)});
            check($sformatf("t1_valid%0d", i), W'(key_valid), W'(1'b1));
            check($sformatf("t1_last%0d", i),  W'(key_last), W'(i == NK - 1));
            check($sformatf("t1_done%0d", i),  W'(done), W'(1'b0));
            step();
        end
        check("t1_done",      W'(done), W'(1'b1));
        check("t1_valid_end", W'(key_valid), W'(1'b0));
        check("t1_busy_end",  W'(busy), W'(1'b0));
        check("t1_err",       W'(err), W'(1'b0));
        check("t1_loaded_kept", W'(loaded), W'(11'h7ff));
        step();
        check("t1_done_pulse", W'(done), W'(1'b0));

        // ---- incomplete bitmap start ----
        do_clear();
        check("t2_cleared", W'(loaded), '0);
        for (int i = 0; i < NK - 1; i++) begin
            write_key(4'(i), {120'h0, 8'(i)});
        end
        check("t2_loaded", W'(loaded), W'(11'h3ff));
        pulse_start();
        check("t2_valid", W'(key_valid), W'(1'b0));
        check("t2_busy",  W'(busy), W'(1'b0));
        check("t2_err",   W'(err), W'(1'b1));
        do_clear();
        check("t2_err_clr",    W'(err), W'(1'b0));
        check("t2_loaded_clr", W'(loaded), '0);

        // ---- backpressure: ready alternates 0/1 starting at 0 ----
        load_all();
        key_ready = 1'b0;
        pulse_start();
        for (int k = 0; k < 2 * NK; k++) begin
            key_ready = k[0];
            check($sformatf("t3_idx_c%0d", k), W'(key_idx), W'(k / 2));
            check($sformatf("t3_key_c%0d", k), key_out, {120'h0, 8'(k / 2)});
            check($sformatf("t3_valid_c%0d", k), W'(key_valid), W'(1'b1));
            step();
        end
        key_ready = 1'b0;
        check("t3_done",  W'(done), W'(1'b1));
        check("t3_valid_end", W'(key_valid), W'(1'b0));

        // ---- out-of-range write, write during RUN ----
        do_clear();
        load_all();
        write_key(4'd3, K3_ALT);
        write_key(4'd12, '1);
        check("t4_err_oor",    W'(err), W'(1'b1));
        check("t4_loaded_oor", W'(loaded), W'(11'h7ff));
        do_clear();
        load_all();
        write_key(4'd3, K3_ALT);
        check("t4_err_pre", W'(err), W'(1'b0));
        key_ready = 1'b0;
        pulse_start();
        write_key(4'd3, K3_RUN);
        check("t4_err_run", W'(err), W'(1'b1));
        check("t4_hold_idx", W'(key_idx), '0);
        key_ready = 1'b1;
        for (int i = 0; i < NK; i++) step();
        check("t4_done1", W'(done), W'(1'b1));
        pulse_start();
        step();
        step();
        step();
        check("t4_idx3", W'(key_idx), W'(4'd3));
        check("t4_key3", key_out, K3_ALT);
        for (int i = 3; i < NK; i++) step();
        check("t4_done2", W'(done), W'(1'b1));

        // ---- reset mid-replay ----
        pulse_start();
        for (int i = 0; i < 5; i++) step();
        check("t5_idx5", W'(key_idx), W'(4'd5));
        rst = 1'b1;
        #1;
        check("t5_valid",  W'(key_valid), W'(1'b0));
        check("t5_busy",   W'(busy), W'(1'b0));
        check("t5_loaded", W'(loaded), '0);
        check("t5_done",   W'(done), W'(1'b0));
        check("t5_idx",    W'(key_idx), '0);
        step();
        rst = 1'b0;
        step();
        check("t5_done_after", W'(done), W'(1'b0));
        pulse_start();
        check("t5_err",   W'(err), W'(1'b1));
        check("t5_valid2", W'(key_valid), W'(1'b0));

        // ---- two replays back to back without reload ----
        do_clear();
        load_all();
        key_ready = 1'b1;
        pulse_start();
        for (int i = 0; i < NK; i++) begin
            rec_q.push_back(key_out);
            check($sformatf("t6a_key%0d", i), key_out, {120'h0, 8'(i)});
            step();
        end
        check("t6a_done", W'(done), W'(1'b1));
        pulse_start();
        for (int i = 0; i < NK; i++) begin
            check($sformatf("t6b_key%0d", i), key_out, rec_q.pop_front());
            check($sformatf("t6b_idx%0d", i), W'(key_idx), W'(i));
            step();
        end
        check("t6b_done", W'(done), W'(1'b1));
        check("t6_err",   W'(err), W'(1'b0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/round_key_mux11.md
# round_key_mux11

Gathering end of the 1-to-11 round-key distribution path in the cipher unit. The block collects up to 11 round keys written by index into a local key store. On `start` it replays them in order 0..10 to the cipher datapath over a valid/ready stream. It replaces direct fan-out where the round datapath consumes one key per round through a single port.

## Interface

Parameters:
- `W`, 128, round-key width in bits
- `NK`, 11, number of key slots (indices 0..NK-1); fixed at 11 for AES-128

Ports:
- `clk`  in  1  single clock; all state on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `wr_en`  in  1  write strobe for the key store
- `wr_idx`  in  4  slot index for the write
- `wr_key`  in  W  key data for the write
- `clear`  in  1  clears all slot-loaded flags; effective in IDLE only
- `start`  in  1  single-cycle request to begin replay
- `key_out`  out  W  current round key, registered
- `key_idx`  out  4  index of `key_out`, registered
- `key_valid`  out  1  `key_out`/`key_idx` valid
- `key_ready`  in  1  consumer accepts the current key
- `key_last`  out  1  high with `key_valid` when `key_idx`==10
- `busy`  out  1  high in RUN
- `done`  out  1  one-cycle pulse after the last handshake
- `loaded`  out  NK  per-slot loaded flags
- `err`  out  1  sticky error flag; cleared only by `rst` or `clear`

## Operation

- Key store: NK×W registers plus the `loaded` bitmap.
- Write in IDLE with `wr_idx`<NK: stores `wr_key` and sets `loaded[wr_idx]`. Rewriting a slot overwrites it.
- Write with `wr_idx`≥NK (11..15): ignored, sets `err`.
- Write in RUN: ignored (store locked), sets `err`.
- `clear` in IDLE: `loaded`←0 and `err`←0. Key data is not zeroed. `clear` in RUN is ignored.
- FSM states: IDLE, RUN.
  - IDLE→RUN on `start` when `loaded`==all ones, sampled before any same-cycle write.
  - `start` with an incomplete bitmap: stays IDLE, sets `err`.
  - `start` in RUN: ignored, no error.
  - RUN: emits slot `ptr`, with `ptr` starting at 0.
  - Handshake = `key_valid & key_ready`. On a handshake with `ptr`<10, increment `ptr` and present the next key.
  - Handshake with `ptr`==10 → IDLE, `done` pulses, `ptr`←0.
- `key_out`, `key_idx` and `key_valid` are held stable while `key_valid & !key_ready`.
- `loaded` persists after replay, so a second `start` replays again without reloading.
- `wr_en`, `clear` and `start` in the same IDLE cycle:
  - `clear` wins over the write; `err` ends at 0 unless the write itself was out of range.
  - `start` is evaluated on the pre-cycle bitmap.

## Timing

- Reset values:
  - `key_out`=0, `key_idx`=0, `key_valid`=0, `key_last`=0
  - `busy`=0, `done`=0, `loaded`=0, `err`=0
  - FSM in IDLE, `ptr`=0
- Key store contents are don't-care after reset.
- Write latency: `loaded[i]` is visible the cycle after the `wr_en` edge.
- Start latency: `start` accepted at edge t gives `key_valid`=1, `key_idx`=0 and `busy`=1 after edge t.
- Throughput: one key per cycle with `key_ready` held high. Eleven consecutive handshakes. `done`=1 for the one cycle following the idx-10 handshake. `key_valid` and `busy` drop in that same cycle.
- Backpressure: no combinational path from `key_ready` to `key_valid`. `key_ready` may toggle every cycle.
- Reset asserted mid-RUN: all outputs go to their reset values immediately (asynchronous). The stream is abandoned with no `done`, and `loaded` is cleared.

## Test plan

- Load slots 0..10 with `wr_key`=`{120'h0, idx[7:0]}`, then pulse `start`, `key_ready`=1.
  - Expect `key_idx` 0..10 on 11 consecutive cycles, `key_out` low byte equal to the index.
  - Expect `key_last` only at idx 10, `done` one cycle later, `err`=0.
- Load slots 0..9 only, pulse `start`.
  - Expect to stay IDLE, `key_valid`=0, `err`=1.
  - Then `clear` → `err`=0, `loaded`=0.
- Full load, `start`, `key_ready` alternating 1/0 starting at 0.
  - Expect each key held stable across its stall cycle.
  - Expect idx 0..10 delivered in 22 cycles, then `done`.
- Write `wr_idx`=12 in IDLE, and write slot 3 during RUN.
  - Expect `err`=1 in both cases.
  - Expect slot 3 replayed with its pre-RUN value on the next `start`.
- Assert `rst` while `key_idx`=5 in RUN.
  - Expect immediate `key_valid`=0, `busy`=0, `loaded`=0, no `done`.
  - Expect a later `start` without reload to set `err`.
- Replay twice in a row without reloading.
  - Expect identical 11-key sequences and two `done` pulses.
